// File: rtl/factor_pkg.sv
// Shared constants for the factorization quiz: display state codes, candidate
// codes, primes per candidate and the divisibility lookup used to judge answers.
package factor_pkg;

   typedef enum logic [3:0] {
      ST_READY    = 4'b0010,
      ST_QUESTION = 4'b0011,
      ST_INPUT    = 4'b0100,
      ST_DRAW     = 4'b0110,
      ST_WRONG    = 4'b0111,
      ST_GOOD     = 4'b1000,
      ST_OUCH     = 4'b1001,
      ST_WIN      = 4'b1010,
      ST_LOSE     = 4'b1011
   } state_e;

   localparam logic [3:0] DIN_NONE = 4'd0;
   localparam logic [3:0] DIN_P2   = 4'd1;
   localparam logic [3:0] DIN_P3   = 4'd2;
   localparam logic [3:0] DIN_P5   = 4'd3;
   localparam logic [3:0] DIN_P7   = 4'd4;

   localparam logic [3:0] PRIME_OF_CODE [5] = '{4'd0, 4'd2, 4'd3, 4'd5, 4'd7};

   localparam logic [6:0] SCORE_MAX = 7'd99;

   // Row = candidate code - 1, bit = question - 2; set where the prime divides it.
   localparam logic [7:0] DIVIDES_LUT [4] = '{8'h55, 8'h92, 8'h08, 8'h20};

   function automatic logic prime_divides(input logic [3:0] din, input logic [3:0] que);
      logic [1:0] code_idx;
      logic [2:0] que_idx;
      code_idx = 2'(din - 4'd1);
      que_idx  = 3'(que - 4'd2);
      if (din == DIN_NONE || din > DIN_P7 || que < 4'd2 || que > 4'd9) begin
         return 1'b0;
      end
      return DIVIDES_LUT[code_idx][que_idx];
   endfunction

endpackage

// File: rtl/factor_game_ctrl_btn_edge.sv
// Rising-edge detector for one synchronized push-button level; the press pulse
// is registered so downstream logic sees a clean one-cycle strobe.
module btn_edge (
   input  logic clk_i,
   input  logic rst_i,
   input  logic btn_i,
   output logic press_o
);

   logic dly_q;
   logic press_q;

   // Delayed copy clears on reset, so a button held through reset yields one press.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         dly_q   <= 1'b0;
         press_q <= 1'b0;
      end else begin
         dly_q   <= btn_i;
         press_q <= btn_i & ~dly_q;
      end
   end

   assign press_o = press_q;

endmodule

// File: rtl/factor_game_ctrl.sv
// Factorization quiz controller: question LFSR, shared phase timer, answer
// judging and saturating score driving the STATE/QUE/DIN display bus.
module factor_game_ctrl
   import factor_pkg::*;
#(
   parameter int QUE_CYCLES    = 50000000,
   parameter int INPUT_CYCLES  = 250000000,
   parameter int RESULT_CYCLES = 100000000,
   parameter int TMR_W         = 28
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       BTN_START,
   input  logic       BTN_NEXT,
   input  logic       BTN_OK,
   output logic [3:0] STATE,
   output logic [3:0] QUE,
   output logic [3:0] DIN,
   output logic [6:0] SCORE
);

   localparam logic [TMR_W-1:0] QUE_LAST    = TMR_W'(QUE_CYCLES - 1);
   localparam logic [TMR_W-1:0] INPUT_LAST  = TMR_W'(INPUT_CYCLES - 1);
   localparam logic [TMR_W-1:0] RESULT_LAST = TMR_W'(RESULT_CYCLES - 1);

   logic [2:0] btn_raw;
   logic [2:0] press;
   logic       press_start;
   logic       press_next;
   logic       press_ok;
   logic       ok_valid;

   state_e           state_q, state_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic [3:0]       que_q, que_d;
   logic [3:0]       din_q, din_d;
   logic [6:0]       score_q, score_d;
   logic [7:0]       lfsr_q;

   assign btn_raw = {BTN_OK, BTN_NEXT, BTN_START};

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_btn
         btn_edge u_btn_edge (
            .clk_i   (CLK),
            .rst_i   (RST),
            .btn_i   (btn_raw[gi]),
            .press_o (press[gi])
         );
      end
   endgenerate

   assign press_start = press[0];
   assign press_next  = press[1];
   assign press_ok    = press[2];
   assign ok_valid    = press_ok && (din_q != DIN_NONE);

   // Free-running x^8+x^6+x^5+x^4+1 sequence; seeded non-zero so it never locks up.
   always_ff @(posedge CLK) begin
      if (RST) begin
         lfsr_q <= 8'h01;
      end else begin
         lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_READY;
         timer_q <= '0;
         que_q   <= 4'd0;
         din_q   <= DIN_NONE;
         score_q <= 7'd0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         que_q   <= que_d;
         din_q   <= din_d;
         score_q <= score_d;
      end
   end

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      que_d   = que_q;
      din_d   = din_q;
      score_d = score_q;
      case (state_q)
         ST_READY: begin
            if (press_start) begin
               que_d   = {1'b0, lfsr_q[2:0]} + 4'd2;
               din_d   = DIN_NONE;
               timer_d = '0;
               state_d = ST_QUESTION;
            end
         end
         ST_QUESTION: begin
            if (timer_q == QUE_LAST) begin
               timer_d = '0;
               state_d = ST_INPUT;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         ST_INPUT: begin
            timer_d = timer_q + 1'b1;
            // A valid OK beats both a simultaneous NEXT and the timeout.
            if (ok_valid) begin
               timer_d = '0;
               if (prime_divides(din_q, que_q)) begin
                  state_d = ST_GOOD;
                  if (score_q < SCORE_MAX) begin
                     score_d = score_q + 7'd1;
                  end
               end else begin
                  state_d = ST_WRONG;
               end
            end else begin
               if (timer_q == INPUT_LAST) begin
                  timer_d = '0;
                  state_d = ST_OUCH;
               end
               if (press_next) begin
                  din_d = (din_q == DIN_P7) ? DIN_P2 : din_q + 4'd1;
               end
            end
         end
         ST_GOOD, ST_WRONG, ST_OUCH: begin
            if (timer_q == RESULT_LAST) begin
               timer_d = '0;
               din_d   = DIN_NONE;
               state_d = ST_READY;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         default: begin
            timer_d = '0;
            din_d   = DIN_NONE;
            state_d = ST_READY;
         end
      endcase
   end

   always_comb begin
      STATE = state_q;
      QUE   = que_q;
      DIN   = din_q;
      SCORE = score_q;
   end

endmodule

// File: doc/factor_game_ctrl.md
Name: factor_game_ctrl

Overview:
- Game controller for the factorization quiz. Drives the STATE/QUE/DIN bus that the 7-segment decoder renders.
- Turns raw push-button levels into game progress:
  - issues a pseudo-random question number 2..9;
  - lets the player cycle through prime candidates 2/3/5/7;
  - judges the answer and holds a result state for a fixed time.
- Sits between the board button inputs and the per-digit display decoders.

Parameters:
- QUE_CYCLES, 50000000, cycles the question is shown before input opens.
- INPUT_CYCLES, 250000000, answer window in cycles before timeout.
- RESULT_CYCLES, 100000000, cycles a result state is held before returning to READY.
- TMR_W, 28, width of the shared phase timer; must cover the largest *_CYCLES value.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous, active-high reset.
- BTN_START  in  1  raw level, high = pressed; already synchronized to CLK.
- BTN_NEXT  in  1  raw level; advances the candidate selection.
- BTN_OK  in  1  raw level; submits the candidate.
- STATE  out  4  game state code.
- QUE  out  4  question number, 2..9.
- DIN  out  4  candidate code: 0 = none, 1 = prime 2, 2 = prime 3, 3 = prime 5, 4 = prime 7.
- SCORE  out  7  count of correct answers, saturates at 99.

Behaviour:
- One clock domain (CLK). RST is synchronous and active-high; it is sampled only on the rising CLK edge.
- Reset values: STATE = READY (0010), QUE = 0, DIN = 0, SCORE = 0, timer = 0, LFSR = 8'h01.
- Button edges:
  - each button has a 1-cycle delayed copy; press = current & ~delayed;
  - a held button produces exactly one press;
  - delayed copies reset to 0, so a button held through reset registers a press on the first cycle after reset.
- LFSR:
  - 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, shifts every cycle in all states;
  - never all-zero.
- State codes: READY 0010, QUESTION 0011, INPUT 0100, WRONG 0111, GOOD 1000, OUCH 1001. All other codes are unused.
- READY:
  - on a START press: QUE <= {1'b0, lfsr[2:0]} + 2, DIN <= 0, timer <= 0, go to QUESTION;
  - NEXT and OK presses are ignored.
- QUESTION:
  - timer increments each cycle;
  - when timer == QUE_CYCLES-1: timer <= 0, go to INPUT;
  - all button presses are ignored.
- INPUT:
  - timer increments each cycle.
  - NEXT press: DIN steps 0→1→2→3→4→1 (wraps to 1, never back to 0).
  - OK press with DIN == 0: ignored.
  - OK press with DIN != 0: compare the selected prime against QUE.
    - prime divides QUE: go to GOOD and increment SCORE (saturating at 99);
    - prime does not divide QUE: go to WRONG.
    - in both cases timer <= 0.
  - Division check is a 4-entry x 8-value constant lookup, not a divider.
  - OK and NEXT pressed in the same cycle: OK wins and judges the pre-increment DIN; DIN is not updated.
  - timer == INPUT_CYCLES-1 with no valid OK that cycle: go to OUCH, timer <= 0.
  - A valid OK on the timeout cycle wins over the timeout.
- GOOD / WRONG / OUCH:
  - hold for RESULT_CYCLES cycles, then go to READY with DIN <= 0;
  - QUE and SCORE are held;
  - buttons are ignored, including START.
- Latency: a press edge on cycle n changes outputs on cycle n+2 (one cycle for edge detect, one for the registered update).
- All outputs are registered; there is no combinational path from inputs to outputs.
- RST asserted in any state returns everything to reset values on the next edge. SCORE is cleared by reset.

Decomposition:
- Shared package factor_pkg holds:
  - the 4-bit state code constants (READY, QUESTION, INPUT, WRONG, GOOD, OUCH, plus DRAW 0110, WIN 1010, LOSE 1011 reserved for the versus mode);
  - the DIN candidate codes and the prime-per-code constants.
- One natural sub-module: btn_edge, which holds the delayed register and rising-edge pulse for one button and is instantiated three times.
- The FSM, timer, LFSR and score counter stay in factor_game_ctrl.

Test Plan:
- Reset and start: after reset, STATE=0010, SCORE=0. Press START while lfsr[2:0]=3'b100 (known-seed cycle count) → STATE=0011 and QUE=6 two cycles later. With QUE_CYCLES=4, STATE=0100 exactly 4 cycles after entering QUESTION.
- Correct answer: QUE=6, press NEXT twice (DIN=2, prime 3), press OK → STATE=1000 and SCORE=1. With RESULT_CYCLES=3, STATE=0010 three cycles after entering GOOD, with DIN=0.
- Wrong answer and selection wrap:
  - QUE=9, press NEXT 5 times → DIN sequence 1,2,3,4,1;
  - press NEXT 2 more times → DIN=3 (prime 5), press OK → STATE=0111, SCORE unchanged.
- Timeout and collisions, with INPUT_CYCLES=8:
  - no presses → OUCH (1001) on the 8th cycle;
  - repeat with a valid OK landing on the timeout cycle → GOOD or WRONG, not OUCH;
  - OK+NEXT in the same cycle with DIN=1 → judged as prime 2, DIN stays 1.
- Guards and reset:
  - OK with DIN=0 in INPUT → stays 0100;
  - START held continuously → only one game starts;
  - RST pulsed during QUESTION and during GOOD → next cycle STATE=0010, QUE=0, DIN=0, SCORE=0;
  - force SCORE to 99 via repeated correct answers → remains 99.
